// File: rtl/instr_reader_exec.sv
// ---------------------------------------------------------------------------
// instr_reader_exec
//
// Read-side engine for the instruction register. A run walks `count` entries
// starting at `first_addr` (wrapping at the top of the register). For each
// entry it reads the opcode and operands, computes the result, and presents
// one beat on a valid/ready result stream.
//
// Per-entry flow: FETCH (drive read_pointer, capture the word) -> EXEC
// (compute and register the result) -> OUT (hold the beat until
// res_valid & res_ready). After the last handshake the FSM spends one cycle
// in DONE, where `done` pulses, and then returns to IDLE.
//
// Optional feature (macro RESULT_STATS_EN):
//   Adds stat_beats (handshakes) and stat_errs (beats that flagged div0 or
//   illegal). Both saturate at 16'hFFFF and clear on reset and on an
//   accepted start.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             run request, accepted only while idle
//   first_addr, count run range, sampled on an accepted start
//   read_pointer      address to the instruction register read port
//   opcode_in,
//   operand_a_in,
//   operand_b_in      combinational read data at read_pointer
//   res_valid/ready   result stream handshake
//   result            signed 2*OPND_W result
//   res_addr,
//   res_opcode        entry address and opcode of the beat
//   res_div0          DIV/MOD with operand b == 0
//   res_illegal       opcode 8..15
//   busy              high while a run is in FETCH/EXEC/OUT
//   done              one-cycle pulse at the end of a run
//   stat_beats,
//   stat_errs         (RESULT_STATS_EN only) result statistics
// ---------------------------------------------------------------------------
module instr_reader_exec #(
    parameter int ADDR_W = 5,
    parameter int OPND_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          first_addr,
    input  logic [ADDR_W:0]            count,
    output logic [ADDR_W-1:0]          read_pointer,
    input  logic [3:0]                 opcode_in,
    input  logic [OPND_W-1:0]          operand_a_in,
    input  logic [OPND_W-1:0]          operand_b_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*OPND_W-1:0]        result,
    output logic [ADDR_W-1:0]          res_addr,
    output logic [3:0]                 res_opcode,
    output logic                       res_div0,
    output logic                       res_illegal,
    output logic                       busy,
`ifdef RESULT_STATS_EN
    output logic [15:0]                stat_beats,
    output logic [15:0]                stat_errs,
`endif
    output logic                       done
);

    localparam int RES_W = 2 * OPND_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_addr;
    logic [ADDR_W:0]           r_remaining;
    logic [3:0]                r_opc;
    logic [OPND_W-1:0]         r_a;
    logic [OPND_W-1:0]         r_b;
    logic signed [RES_W-1:0]   r_result;
    logic [ADDR_W-1:0]         r_res_addr;
    logic [3:0]                r_res_opc;
    logic                      r_valid;
    logic                      r_div0;
    logic                      r_illegal;
    logic                      r_busy;
    logic                      r_done;

    // Operands are widened to the result width first, so ADD/SUB/MULT cannot
    // overflow and DIV of the most negative value by -1 is representable.
    logic signed [RES_W-1:0]   w_a_ext;
    logic signed [RES_W-1:0]   w_b_ext;
    logic signed [RES_W-1:0]   w_res;
    logic                      w_div0;
    logic                      w_illegal;
    logic                      w_b_zero;
    logic                      w_handshake;
    logic                      w_start_ok;

    assign w_a_ext     = {{OPND_W{r_a[OPND_W-1]}}, r_a};
    assign w_b_ext     = {{OPND_W{r_b[OPND_W-1]}}, r_b};
    assign w_b_zero    = (r_b == '0);
    assign w_handshake = (r_state == S_OUT) && res_ready;
    assign w_start_ok  = (r_state == S_IDLE) && start;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement leaves a value unassigned (no latches).
    always_comb begin
        w_res     = '0;
        w_div0    = 1'b0;
        w_illegal = 1'b0;
        case (r_opc)
            4'd0: w_res = '0;
            4'd1: w_res = w_a_ext;
            4'd2: w_res = w_b_ext;
            4'd3: w_res = w_a_ext + w_b_ext;
            4'd4: w_res = w_a_ext - w_b_ext;
            4'd5: w_res = w_a_ext * w_b_ext;
            4'd6: begin
                if (w_b_zero) w_div0 = 1'b1;
                else          w_res  = w_a_ext / w_b_ext;
            end
            4'd7: begin
                if (w_b_zero) w_div0 = 1'b1;
                else          w_res  = w_a_ext % w_b_ext;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: all state here is control or a small set of output
            // registers, so everything is reset; a reset mid-run aborts it
            // without a further beat or done pulse.
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_opc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_res_addr  <= '0;
            r_res_opc   <= '0;
            r_valid     <= 1'b0;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a pulse: cleared every cycle unless a branch sets it.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_addr      <= first_addr;
                            r_remaining <= count;
                            r_busy      <= 1'b1;
                            r_state     <= S_FETCH;
                        end else begin
                            // Empty run: straight to DONE, no beats.
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    // read_pointer already shows r_addr; capture the word.
                    r_opc   <= opcode_in;
                    r_a     <= operand_a_in;
                    r_b     <= operand_b_in;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result   <= w_res;
                    r_div0     <= w_div0;
                    r_illegal  <= w_illegal;
                    r_res_addr <= r_addr;
                    r_res_opc  <= r_opc;
                    r_valid    <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    // Beat fields are only rewritten in EXEC, so they stay
                    // stable for as long as the consumer stalls.
                    if (res_ready) begin
                        r_valid     <= 1'b0;
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == 1) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RESULT_STATS_EN
    logic [15:0] r_stat_beats;
    logic [15:0] r_stat_errs;

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_stat_beats <= '0;
            r_stat_errs  <= '0;
        end else if (w_handshake) begin
            if (r_stat_beats != 16'hFFFF)
                r_stat_beats <= r_stat_beats + 16'd1;
            if ((r_div0 || r_illegal) && (r_stat_errs != 16'hFFFF))
                r_stat_errs <= r_stat_errs + 16'd1;
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_errs  = r_stat_errs;
`endif

    assign read_pointer = r_addr;
    assign result       = r_result;
    assign res_addr     = r_res_addr;
    assign res_opcode   = r_res_opc;
    assign res_valid    = r_valid;
    assign res_div0     = r_div0;
    assign res_illegal  = r_illegal;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_instr_reader_exec.sv
// ---------------------------------------------------------------------------
// tb_instr_reader_exec
//
// Directed bench for instr_reader_exec. A small array stands in for the
// instruction register. Each directed run pushes its hand-computed beats into
// a queue; an independent monitor compares every presented beat against the
// queue head and pops it on handshake. Compile with +define+RESULT_STATS_EN
// to also exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_instr_reader_exec;

    localparam int ADDR_W = 5;
    localparam int OPND_W = 32;

    typedef struct packed {
        logic signed [63:0] res;
        logic [4:0]         addr;
        logic [3:0]         opc;
        logic               div0;
        logic               ill;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [ADDR_W-1:0]   first_addr;
    logic [ADDR_W:0]     count;
    logic [ADDR_W-1:0]   read_pointer;
    logic [3:0]          opcode_in;
    logic [OPND_W-1:0]   operand_a_in;
    logic [OPND_W-1:0]   operand_b_in;
    logic                res_valid;
    logic                res_ready;
    logic [2*OPND_W-1:0] result;
    logic [ADDR_W-1:0]   res_addr;
    logic [3:0]          res_opcode;
    logic                res_div0;
    logic                res_illegal;
    logic                busy;
    logic                done;
`ifdef RESULT_STATS_EN
    logic [15:0]         stat_beats;
    logic [15:0]         stat_errs;
`endif

    logic [3:0]          m_opc [32];
    logic [OPND_W-1:0]   m_a   [32];
    logic [OPND_W-1:0]   m_b   [32];

    beat_t               exp_q[$];
    int                  checks   = 0;
    int                  failures = 0;

    always #5 clk = ~clk;

    assign opcode_in    = m_opc[read_pointer];
    assign operand_a_in = m_a[read_pointer];
    assign operand_b_in = m_b[read_pointer];

    instr_reader_exec #(.ADDR_W(ADDR_W), .OPND_W(OPND_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_addr   (first_addr),
        .count        (count),
        .read_pointer (read_pointer),
        .opcode_in    (opcode_in),
        .operand_a_in (operand_a_in),
        .operand_b_in (operand_b_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .result       (result),
        .res_addr     (res_addr),
        .res_opcode   (res_opcode),
        .res_div0     (res_div0),
        .res_illegal  (res_illegal),
        .busy         (busy),
`ifdef RESULT_STATS_EN
        .stat_beats   (stat_beats),
        .stat_errs    (stat_errs),
`endif
        .done         (done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_entry(input int idx, input logic [3:0] o,
                             input logic signed [31:0] a, input logic signed [31:0] b);
        m_opc[idx] = o;
        m_a[idx]   = a;
        m_b[idx]   = b;
    endtask

    task automatic expect_beat(input logic signed [63:0] res, input logic [4:0] addr,
                               input logic [3:0] opc, input logic div0, input logic ill);
        beat_t e;
        e.res  = res;
        e.addr = addr;
        e.opc  = opc;
        e.div0 = div0;
        e.ill  = ill;
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; returns just after the posedge that
    // sampled start.
    task automatic start_run(input logic [4:0] fa, input logic [5:0] cnt);
        first_addr = fa;
        count      = cnt;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for done, then checks its shape: busy low alongside it,
    // gone the next cycle, and all expected beats consumed by then.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done_seen"}, done, 1'b1);
        check({name, "_busy_at_done"}, busy, 1'b0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        tick(1);
        check({name, "_done_pulse"}, done, 1'b0);
    endtask

    // Monitor: every presented beat must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!reset && res_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", res_valid, 1'b0);
            end else begin
                beat_t act;
                act.res  = result;
                act.addr = res_addr;
                act.opc  = res_opcode;
                act.div0 = res_div0;
                act.ill  = res_illegal;
                check("beat", act, exp_q[0]);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) set_entry(i, 4'd0, 0, 0);
        reset      = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        count      = '0;
        res_ready  = 1'b1;
        tick(3);
        check("reset_state",
              {read_pointer, result, res_addr, res_opcode, res_valid, res_div0, res_illegal, busy, done},
              '0);
        reset = 1'b0;
        tick(1);

        // Test 1: reset mid-run aborts; no beat, no done.
        set_entry(7, 4'd3, 1, 2);
        set_entry(8, 4'd3, 3, 4);
        set_entry(9, 4'd3, 5, 6);
        start_run(5'd7, 6'd3);
        check("t1_read_pointer", read_pointer, 5'd7);
        tick(1);
        check("t1_busy_mid_run", busy, 1'b1);
        reset = 1'b1;
        tick(3);
        check("t1_reset_outputs",
              {read_pointer, result, res_addr, res_opcode, res_valid, res_div0, res_illegal, busy, done},
              '0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t1_quiet_after_reset", {res_valid, done, busy}, 3'b000);
        end

        // Test 2: ADD/MULT/SUB, latency from start to first res_valid.
        set_entry(0, 4'd3, 5, -7);
        set_entry(1, 4'd5, -3, 4);
        set_entry(2, 4'd4, 10, 20);
        expect_beat(-2,  5'd0, 4'd3, 1'b0, 1'b0);
        expect_beat(-12, 5'd1, 4'd5, 1'b0, 1'b0);
        expect_beat(-10, 5'd2, 4'd4, 1'b0, 1'b0);
        first_addr = 5'd0;
        count      = 6'd3;
        start      = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end while (!res_valid && n < 10);
        check("t2_first_valid_latency", n, 3);
        wait_done("t2");

        // Test 3: DIV by zero, MOD/DIV truncation toward zero, illegal opcode.
        set_entry(3, 4'd6, 7, 0);
        set_entry(4, 4'd7, -7, 2);
        set_entry(5, 4'd6, -7, 2);
        set_entry(6, 4'd12, 1, 1);
        expect_beat(0,  5'd3, 4'd6,  1'b1, 1'b0);
        expect_beat(-1, 5'd4, 4'd7,  1'b0, 1'b0);
        expect_beat(-3, 5'd5, 4'd6,  1'b0, 1'b0);
        expect_beat(0,  5'd6, 4'd12, 1'b0, 1'b1);
        start_run(5'd3, 6'd4);
        wait_done("t3");

        // Test 4: address wrap 31 -> 0 -> 1.
        set_entry(31, 4'd4, -5, 3);
        expect_beat(-8,  5'd31, 4'd4, 1'b0, 1'b0);
        expect_beat(-2,  5'd0,  4'd3, 1'b0, 1'b0);
        expect_beat(-12, 5'd1,  4'd5, 1'b0, 1'b0);
        start_run(5'd31, 6'd3);
        wait_done("t4");

        // Test 5: backpressure hold, start while busy ignored, count == 0.
        set_entry(10, 4'd1, 123, 0);
        set_entry(11, 4'd2, 0, -9);
        set_entry(12, 4'd5, 32'sh8000_0000, 32'sh8000_0000);
        expect_beat(123, 5'd10, 4'd1, 1'b0, 1'b0);
        expect_beat(-9,  5'd11, 4'd2, 1'b0, 1'b0);
        expect_beat(64'sh4000_0000_0000_0000, 5'd12, 4'd5, 1'b0, 1'b0);
        res_ready = 1'b0;
        start_run(5'd10, 6'd3);
        n = 0;
        while (!res_valid && n < 10) begin
            tick(1);
            n++;
        end
        check("t5_valid_seen", res_valid, 1'b1);
        first_addr = 5'd20;
        count      = 6'd1;
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 3);
            tick(1);
            check("t5_hold_valid", res_valid, 1'b1);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        wait_done("t5");
        start_run(5'd0, 6'd0);
        check("t5_count0_done", {done, busy, res_valid}, 3'b100);
        tick(1);
        check("t5_count0_after", {done, busy, res_valid}, 3'b000);
        tick(3);
        check("t5_no_stray_beats", exp_q.size(), 0);

`ifdef RESULT_STATS_EN
        // Test 6: statistics over 4 entries with one illegal and one DIV by 0.
        set_entry(20, 4'd9, 3, 4);
        set_entry(21, 4'd6, 8, 0);
        set_entry(22, 4'd3, 1, 1);
        set_entry(23, 4'd0, 5, 5);
        expect_beat(0, 5'd20, 4'd9, 1'b0, 1'b1);
        expect_beat(0, 5'd21, 4'd6, 1'b1, 1'b0);
        expect_beat(2, 5'd22, 4'd3, 1'b0, 1'b0);
        expect_beat(0, 5'd23, 4'd0, 1'b0, 1'b0);
        start_run(5'd20, 6'd4);
        wait_done("t6");
        check("t6_stat_beats", stat_beats, 16'd4);
        check("t6_stat_errs", stat_errs, 16'd2);
        start_run(5'd0, 6'd0);
        tick(1);
        check("t6_stats_cleared", {stat_beats, stat_errs}, 32'd0);
`endif

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
